// File: rtl/mcu_ctrl_pkg.sv
// mcu_ctrl_pkg
//   Shared constants for the multicycle main control unit:
//   - FSM state encodings (4-bit)
//   - instruction opcodes (IR[15:12])
//   - ALUOp class codes consumed by the ALU controller
//   - pc_src and alu_src_b multiplexer encodings
//   - opcode_legal() helper used by the decode-stage illegal check
package mcu_ctrl_pkg;

  // FSM states
  localparam logic [3:0] S_RST    = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXE_R  = 4'd7;
  localparam logic [3:0] S_EXE_I  = 4'd8;
  localparam logic [3:0] S_ALUWB  = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JAL    = 4'd11;
  localparam logic [3:0] S_HALT   = 4'd12;

  // Opcodes
  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_ADDI = 4'b0001;
  localparam logic [3:0] OP_LW   = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BR   = 4'b0100;
  localparam logic [3:0] OP_JAL  = 4'b0101;
  localparam logic [3:0] OP_HALT = 4'b1111;

  // ALUOp classes (shared with the ALU controller)
  localparam logic [1:0] S_T = 2'b00;  // plain add
  localparam logic [1:0] B_T = 2'b01;  // branch compare
  localparam logic [1:0] R_T = 2'b10;  // R-type, funct decides
  localparam logic [1:0] I_T = 2'b11;  // I-type, opcode decides

  // pc_src mux
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // alu_src_b mux
  localparam logic [1:0] ALU_B_REGB = 2'b00;
  localparam logic [1:0] ALU_B_TWO  = 2'b01;
  localparam logic [1:0] ALU_B_IMM  = 2'b10;

  function automatic logic opcode_legal(input logic [3:0] op);
    case (op)
      OP_R, OP_ADDI, OP_LW, OP_SW, OP_BR, OP_JAL, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcu_ctrl_decode.sv
// mcu_ctrl_decode
//   Purely combinational control-word decoder. Every output is a function
//   of the current state only, except ir_write/pc_write in FETCH which
//   follow mem_ready so the IR and PC load on the cycle memory completes.
// Ports:
//   state         in  4  current FSM state
//   mem_ready     in  1  memory completes the current request
//   mem_req .. halted  out  control word for the shared datapath
module mcu_ctrl_decode
  import mcu_ctrl_pkg::*;
(
  input  logic [3:0] state,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic       halted
);

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_SRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_REGB;
    alu_op        = S_T;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    halted        = 1'b0;
    case (state)
      S_FETCH: begin
        // PC + 2 computed while the instruction is read
        mem_req   = 1'b1;
        alu_src_b = ALU_B_TWO;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // branch target precomputed into ALUOut
        alu_src_b = ALU_B_IMM;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
      end
      S_EXE_R: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_REGB;
        alu_op    = R_T;
      end
      S_EXE_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        alu_op    = I_T;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_src_b     = ALU_B_REGB;
        alu_op        = B_T;
        pc_write_cond = 1'b1;
        pc_src        = PC_SRC_ALUOUT;
      end
      S_JAL: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_JUMP;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mcu_ctrl_fsm.sv
// mcu_ctrl_fsm
//   Multicycle main control unit. Holds the state register, next-state
//   logic, the sticky illegal flag and the optional performance counters;
//   the control word itself comes from mcu_ctrl_decode.
// Build option:
//   MCU_PERF_CNT_EN  when defined, cycle_cnt/instret_cnt are live counters;
//                    otherwise both ports are constant 0.
// Parameters:
//   RESET_PC_HOLD    1 stretches S_RST to two cycles after reset release
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   opcode           IR[15:12], valid from DECODE onward
//   mem_ready        memory completes the current request
//   mem_req .. mem_to_reg  datapath control word
//   halted, illegal  sticky stop flags
//   cycle_cnt, instret_cnt  performance counters
module mcu_ctrl_fsm
  import mcu_ctrl_pkg::*;
#(
  parameter int RESET_PC_HOLD = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_src,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] cycle_cnt,
  output logic [15:0] instret_cnt
);

  logic [3:0] state_reg, state_next;
  logic       hold_reg;
  logic       illegal_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_RST: begin
        if (RESET_PC_HOLD != 0 && !hold_reg) state_next = S_RST;
        else                                 state_next = S_FETCH;
      end
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_R:         state_next = S_EXE_R;
          OP_ADDI:      state_next = S_EXE_I;
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_BR:        state_next = S_BRANCH;
          OP_JAL:       state_next = S_JAL;
          default:      state_next = S_HALT;  // HALT and every illegal code
        endcase
      end
      S_MEMADR: state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_next = S_MEMWB;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  if (mem_ready) state_next = S_FETCH;
      S_EXE_R:  state_next = S_ALUWB;
      S_EXE_I:  state_next = S_ALUWB;
      S_ALUWB:  state_next = S_FETCH;
      S_BRANCH: state_next = S_FETCH;
      S_JAL:    state_next = S_FETCH;
      S_HALT:   state_next = S_HALT;
      default:  state_next = S_RST;   // unused encodings recover via reset state
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_RST;
      hold_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // marks that the first S_RST cycle has elapsed
      if (state_reg == S_RST) hold_reg <= 1'b1;
      if (state_reg == S_DECODE && !opcode_legal(opcode)) illegal_reg <= 1'b1;
    end
  end

  assign illegal = illegal_reg;

  mcu_ctrl_decode u_decode (
    .state         (state_reg),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .halted        (halted)
  );

`ifdef MCU_PERF_CNT_EN
  logic [15:0] cycle_cnt_reg;
  logic [15:0] instret_cnt_reg;

  // Counting on the state being entered makes the visible value include the
  // current cycle: the first FETCH reads 1, and the count freezes once HALT
  // is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      if (state_next != S_RST && state_next != S_HALT)
        cycle_cnt_reg <= cycle_cnt_reg + 16'd1;
      // FETCH entered from an execution state retires one instruction
      if (state_next == S_FETCH && state_reg != S_FETCH && state_reg != S_RST)
        instret_cnt_reg <= instret_cnt_reg + 16'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_mcu_ctrl_fsm.sv
// tb_mcu_ctrl_fsm
//   Scoreboard bench for mcu_ctrl_fsm. The driver issues whole instructions
//   (opcode, fetch wait, data wait), acting as the memory, and pushes the
//   expected control word of every cycle, built from per-instruction phase
//   recipes. A separate monitor pops one entry per cycle and compares.
module tb_mcu_ctrl_fsm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  opcode = 4'd0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  alu_op;
  logic        reg_write, mem_to_reg, halted, illegal;
  logic [15:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  mcu_ctrl_fsm dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .i_or_d        (i_or_d),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_src        (pc_src),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .reg_write     (reg_write),
    .mem_to_reg    (mem_to_reg),
    .halted        (halted),
    .illegal       (illegal),
    .cycle_cnt     (cycle_cnt),
    .instret_cnt   (instret_cnt)
  );

`ifdef MCU_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond, pc_src,
  //  alu_src_a, alu_src_b, alu_op, reg_write, mem_to_reg, halted, illegal}
  logic [16:0] ctl_now;
  assign ctl_now = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                    pc_src, alu_src_a, alu_src_b, alu_op, reg_write,
                    mem_to_reg, halted, illegal};

  function automatic logic [16:0] cw(
    input logic mreq, input logic we, input logic iord, input logic irw,
    input logic pcw, input logic pcwc, input logic [1:0] pcs,
    input logic asa, input logic [1:0] asb, input logic [1:0] aop,
    input logic rw, input logic m2r, input logic hlt, input logic ill);
    return {mreq, we, iord, irw, pcw, pcwc, pcs, asa, asb, aop, rw, m2r, hlt, ill};
  endfunction

  // phase recipes taken from the control table
  function automatic logic [16:0] w_fetch(input logic rdy);
    return cw(1, 0, 0, rdy, rdy, 0, 2'b00, 0, 2'b01, 2'b00, 0, 0, 0, 0);
  endfunction
  function automatic logic [16:0] w_halt(input logic ill);
    return cw(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1, ill);
  endfunction
  wire [16:0] W_DECODE = cw(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b10, 2'b00, 0, 0, 0, 0);
  wire [16:0] W_MEMADR = cw(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00, 0, 0, 0, 0);
  wire [16:0] W_MEMRD  = cw(1, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
  wire [16:0] W_MEMWB  = cw(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 1, 0, 0);
  wire [16:0] W_MEMWR  = cw(1, 1, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0, 0);
  wire [16:0] W_EXE_R  = cw(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b00, 2'b10, 0, 0, 0, 0);
  wire [16:0] W_EXE_I  = cw(0, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b11, 0, 0, 0, 0);
  wire [16:0] W_ALUWB  = cw(0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0, 0);
  wire [16:0] W_BRANCH = cw(0, 0, 0, 0, 0, 1, 2'b01, 1, 2'b00, 2'b01, 0, 0, 0, 0);
  wire [16:0] W_JAL    = cw(0, 0, 0, 0, 1, 0, 2'b10, 0, 2'b00, 2'b00, 1, 0, 0, 0);

  typedef struct packed {
    logic [16:0] ctl;
    logic [15:0] cyc;
    logic [15:0] ret;
  } exp_t;

  exp_t        sb_q[$];
  int          tests = 0;
  int          fails = 0;
  logic [15:0] cyc_m = 16'd0;   // non-reset, non-halt cycles including current
  logic [15:0] ret_m = 16'd0;   // completed instructions

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        tests++;
        if (ctl_now !== e.ctl) begin
          fails++;
          $display("FAIL ctl_word t=%0t got=%b required=%b", $time, ctl_now, e.ctl);
        end
        tests++;
        if (cycle_cnt !== e.cyc || instret_cnt !== e.ret) begin
          fails++;
          $display("FAIL counters t=%0t got cyc=%0d ret=%0d required cyc=%0d ret=%0d",
                   $time, cycle_cnt, instret_cnt, e.cyc, e.ret);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic rdy, input logic [3:0] opc,
                      input logic [16:0] w, input bit counted);
    exp_t e;
    @(negedge clk);
    mem_ready = rdy;
    opcode    = opc;
    if (counted) cyc_m = cyc_m + 16'd1;
    e.ctl = w;
    e.cyc = PERF ? cyc_m : 16'd0;
    e.ret = PERF ? ret_m : 16'd0;
    sb_q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    tests++;
    if (ctl_now !== 17'd0 || cycle_cnt !== 16'd0 || instret_cnt !== 16'd0) begin
      fails++;
      $display("FAIL %s t=%0t got ctl=%b cyc=%0d ret=%0d required all zero",
               tag, $time, ctl_now, cycle_cnt, instret_cnt);
    end
  endtask

  // Called with rst_n already low. mid=1: reset was just asserted between
  // edges, so outputs must already be zero.
  task automatic apply_reset(input bit mid);
    exp_t e;
    mem_ready = 1'b0;
    if (mid) begin
      #1 check_zero("reset_async");
    end
    @(negedge clk);
    #2 check_zero("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    cyc_m = 16'd0;
    ret_m = 16'd0;
    e.ctl = 17'd0;
    e.cyc = 16'd0;
    e.ret = 16'd0;
    sb_q.push_back(e);   // the single S_RST cycle after release
    $display("[TB] reset released t=%0t", $time);
  endtask

  // Runs one instruction; returns 1 if it halted the core.
  task automatic run_instr(input logic [3:0] opc, input int fw, input int dw,
                           output bit stopped);
    logic [3:0] junk;
    stopped = 1'b0;
    $display("[TB] instr opc=%b fetch_wait=%0d data_wait=%0d", opc, fw, dw);
    for (int i = 0; i < fw; i++) begin
      junk = 4'($urandom_range(0, 15));
      step(1'b0, junk, w_fetch(1'b0), 1'b1);
    end
    junk = 4'($urandom_range(0, 15));
    step(1'b1, junk, w_fetch(1'b1), 1'b1);
    step(1'($urandom_range(0, 1)), opc, W_DECODE, 1'b1);
    case (opc)
      4'b0000: begin
        step(1'($urandom_range(0, 1)), opc, W_EXE_R, 1'b1);
        step(1'($urandom_range(0, 1)), opc, W_ALUWB, 1'b1);
      end
      4'b0001: begin
        step(1'($urandom_range(0, 1)), opc, W_EXE_I, 1'b1);
        step(1'($urandom_range(0, 1)), opc, W_ALUWB, 1'b1);
      end
      4'b0010: begin
        step(1'($urandom_range(0, 1)), opc, W_MEMADR, 1'b1);
        for (int i = 0; i < dw; i++) step(1'b0, opc, W_MEMRD, 1'b1);
        step(1'b1, opc, W_MEMRD, 1'b1);
        step(1'($urandom_range(0, 1)), opc, W_MEMWB, 1'b1);
      end
      4'b0011: begin
        step(1'($urandom_range(0, 1)), opc, W_MEMADR, 1'b1);
        for (int i = 0; i < dw; i++) step(1'b0, opc, W_MEMWR, 1'b1);
        step(1'b1, opc, W_MEMWR, 1'b1);
      end
      4'b0100: step(1'($urandom_range(0, 1)), opc, W_BRANCH, 1'b1);
      4'b0101: step(1'($urandom_range(0, 1)), opc, W_JAL, 1'b1);
      default: begin
        // HALT or illegal: stopped for good, mem_ready noise ignored
        for (int i = 0; i < 20; i++)
          step(1'($urandom_range(0, 1)), opc, w_halt(opc != 4'b1111), 1'b0);
        stopped = 1'b1;
      end
    endcase
    if (!stopped) ret_m = ret_m + 16'd1;
  endtask

  task automatic reset_in_fetch_wait();
    logic [3:0] junk;
    $display("[TB] reset during fetch wait");
    for (int i = 0; i < 2; i++) begin
      junk = 4'($urandom_range(0, 15));
      step(1'b0, junk, w_fetch(1'b0), 1'b1);
    end
    #3 rst_n = 1'b0;
    apply_reset(1'b1);
  endtask

  initial begin
    bit         stopped;
    logic [3:0] opc;
    int         sel;
    int         guard;

    apply_reset(1'b0);

    // ten zero-wait ADDIs; the following FETCH carries cyc=41, ret=10
    for (int i = 0; i < 10; i++) run_instr(4'b0001, 0, 0, stopped);
    run_instr(4'b0000, 0, 0, stopped);
    run_instr(4'b0010, 0, 3, stopped);
    run_instr(4'b0100, 0, 0, stopped);
    run_instr(4'b0011, 2, 1, stopped);
    run_instr(4'b0101, 1, 0, stopped);

    run_instr(4'b1010, 0, 0, stopped);    // illegal -> halt
    #3 rst_n = 1'b0;
    apply_reset(1'b1);

    reset_in_fetch_wait();
    run_instr(4'b1111, 0, 0, stopped);    // HALT
    #3 rst_n = 1'b0;
    apply_reset(1'b1);

    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 39);
      if (sel == 38)      opc = 4'b1111;
      else if (sel == 39) opc = 4'($urandom_range(6, 14));
      else                opc = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 29) == 0) begin
        reset_in_fetch_wait();
      end else begin
        run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3), stopped);
        if (stopped) begin
          #3 rst_n = 1'b0;
          apply_reset(1'b1);
        end
      end
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    #2;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain got=%0d pending required=0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
